dec_rr_arbiter: RTL

- Round-robin arbiter that shares one 2-to-4 enabled decoder among four requesters.
- Each cycle it decides which requester owns the decoded line and drives the decoder's two select bits and enable.
- It also returns a one-hot grant vector that matches the decoder output.
- A bounded hold counter stops one requester from monopolising the decoder while others wait.

---
 rtl/dec_rr_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/dec_rr_arbiter.sv
// dec_rr_arbiter: round-robin arbiter sharing one 2-to-4 enabled decoder among four requesters
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-high reset
//   req[3:0]   - level-sensitive request vector, bit i is requester i
//   sel_lo     - decoder select LSB (grant index bit 0)
//   sel_hi     - decoder select MSB (grant index bit 1)
//   en         - decoder enable, high while a grant is active
//   gnt[3:0]   - one-hot grant, mirrors the decoder output
//   gnt_change - one-cycle pulse when a new owner first appears on the outputs
module dec_rr_arbiter #(
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic       sel_lo,
    output logic       sel_hi,
    output logic       en,
    output logic [3:0] gnt,
    output logic       gnt_change
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t           st;
    logic [1:0]       owner;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] hold_cnt;

    logic [3:0] others;
    logic [1:0] nxt;
    logic [1:0] pick_idle;
    logic [1:0] pick_sw;
    logic [1:0] idx;
    logic       hold_full;
    logic       sw;
    logic       go;
    logic       rel;

    // First set bit of r scanning s, s+1, s+2, s+3 (mod 4): rotate so s lands
    // at bit 0, priority-encode, then rotate the index back.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] s);
        logic [7:0] dbl;
        logic [3:0] rot;
        dbl = {r, r} >> s;
        rot = dbl[3:0];
        return s + (rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3);
    endfunction

    always_comb begin
        others    = req & ~(4'b0001 << owner);
        nxt       = owner + 2'd1;
        hold_full = hold_cnt == CNT_W'(HOLD_MAX);
        pick_idle = rr_pick(req, ptr);
        // On release req[owner] is already 0, so one pick over "others"
        // serves both the release and the preempt hand-over.
        pick_sw   = rr_pick(others, nxt);
        sw        = st == GRANT && others != 4'b0000 && (!req[owner] || hold_full);
        rel       = st == GRANT && !req[owner];
        go        = (st == IDLE && req != 4'b0000) || sw;
        idx       = st == IDLE ? pick_idle : pick_sw;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= IDLE;
            owner      <= 2'd0;
            ptr        <= 2'd0;
            hold_cnt   <= '0;
            en         <= 1'b0;
            sel_hi     <= 1'b0;
            sel_lo     <= 1'b0;
            gnt        <= 4'b0000;
            gnt_change <= 1'b0;
        end else begin
            gnt_change <= go;
            if (go) begin
                st               <= GRANT;
                owner            <= idx;
                {sel_hi, sel_lo} <= idx;
                en               <= 1'b1;
                gnt              <= 4'b0001 << idx;
                hold_cnt         <= CNT_W'(1);
                if (st == GRANT) ptr <= nxt;
            end else if (rel) begin
                st  <= IDLE;
                ptr <= nxt;
                en  <= 1'b0;
                gnt <= 4'b0000;
            end else if (st == GRANT && !hold_full) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end
endmodule
